// File: rtl/fetch_prefetch_buffer_pkg.sv
// Shared fetch-path constants: word size, widths and the default reset vector.
package fetch_prefetch_buffer_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned ADDR_W     = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_prefetch_buffer_fifo.sv
// Small instruction FIFO for the prefetch buffer. The head word is read
// combinationally so a hit can be served in the same cycle it is requested.
// Flush discards every stored word at once.
module prefetch_fifo
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = INSTR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [DW-1:0]          push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [DW-1:0]          head_data
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          wr_en;

    // Pointer and occupancy update; flush wins over push/pop.
    always_comb begin
        wr_en    = push && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Control state; cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer. Streams sequential words from program memory
// into a small FIFO ahead of the CPU and serves the CPU when its address
// matches the oldest buffered word. Any non-sequential request flushes the
// FIFO, kills the outstanding read and restarts fetching at the new target.
//
// The read decision is made one cycle early and held in rd_pend_q together
// with the registered mem_addr; the strobe is then withheld in a flush cycle,
// so the bus never carries a read that would only be thrown away.
module fetch_prefetch_buffer
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int unsigned    DEPTH    = 4,
    parameter int unsigned    AW       = ADDR_W,
    parameter int unsigned    DW       = INSTR_W,
    parameter logic [AW-1:0]  RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic [DW-1:0] cpu_instr,
    output logic          cpu_valid,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned   CW         = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] STEP       = AW'(WORD_BYTES);
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(WORD_BYTES - 1);
    localparam logic [CW:0]   DEPTH_W    = (CW+1)'(DEPTH);

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] head_pc_q,  head_pc_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          rd_pend_q,  rd_pend_d;
    logic          resp_q,     resp_d;

    logic [AW-1:0] req_addr;
    logic [AW-1:0] fetch_base;
    logic          addr_match;
    logic          hit;
    logic          flush;
    logic          push;
    logic          pop;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    logic [CW:0]   occ_next;
    logic [DW-1:0] fifo_head;

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (mem_rdata),
        .pop       (pop),
        .flush     (flush),
        .count     (fifo_count),
        .head_data (fifo_head)
    );

    // Hit/miss decode, capture, and next-cycle read decision.
    always_comb begin
        req_addr   = cpu_addr & ALIGN_MASK;
        addr_match = (req_addr == head_pc_q);
        flush      = cpu_req && !addr_match;
        hit        = cpu_req && addr_match && (fifo_count != '0);
        pop        = hit;
        // A response arriving in a flush cycle belongs to the old stream.
        push       = resp_q && !flush;
        mem_rd     = rd_pend_q && !flush;
        resp_d     = mem_rd;

        cpu_valid  = hit;
        cpu_instr  = hit ? fifo_head : '0;

        // Occupancy as it will stand after this edge, counting the word
        // still on its way back; only issue if a slot remains for it.
        count_next = flush ? '0 : (fifo_count + CW'(push) - CW'(pop));
        occ_next   = {1'b0, count_next} + (CW+1)'(resp_d);
        rd_pend_d  = (occ_next < DEPTH_W);

        fetch_base = flush ? req_addr : fetch_pc_q;
        mem_addr_d = rd_pend_d ? fetch_base : mem_addr_q;
        fetch_pc_d = rd_pend_d ? (fetch_base + STEP) : fetch_base;

        head_pc_d  = head_pc_q;
        if (flush) begin
            head_pc_d = req_addr;
        end else if (pop) begin
            head_pc_d = head_pc_q + STEP;
        end
    end

    // Fetch/head pointers and the read pipeline; reset restarts at RESET_PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            mem_addr_q <= RESET_PC;
            rd_pend_q  <= 1'b0;
            resp_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            mem_addr_q <= mem_addr_d;
            rd_pend_q  <= rd_pend_d;
            resp_q     <= resp_d;
        end
    end

    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: table-driven vectors, directed corner
// sequences and a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_fetch_prefetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_instr;
    logic        cpu_valid;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    logic        rst_w;
    logic        req_w;
    logic [31:0] addr_w;
    logic [31:0] instr_w;
    logic        valid_w;
    logic        mem_rd_w;
    logic [31:0] mem_addr_w;
    logic [31:0] mem_rdata_w;

    fetch_prefetch_buffer #(
        .DEPTH(DEPTH), .AW(32), .DW(32), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .reset(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_instr(cpu_instr), .cpu_valid(cpu_valid), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    fetch_prefetch_buffer #(
        .DEPTH(DEPTH), .AW(32), .DW(32), .RESET_PC(32'hFFFF_FFF8)
    ) dut_wrap (
        .clk(clk), .reset(rst_w), .cpu_req(req_w), .cpu_addr(addr_w),
        .cpu_instr(instr_w), .cpu_valid(valid_w), .mem_rd(mem_rd_w),
        .mem_addr(mem_addr_w), .mem_rdata(mem_rdata_w)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'hA5A5};
    endfunction

    // Program memory: data valid exactly one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        mem_rdata   <= mem_rd   ? mem_word(mem_addr)   : 32'hBAD0_BAD0;
        mem_rdata_w <= mem_rd_w ? mem_word(mem_addr_w) : 32'hBAD0_BAD0;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: a queue of buffered word addresses plus the
    // fetch/head pointers and one outstanding-read flag.
    logic [31:0] m_q[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_head_pc;
    logic [31:0] m_infl_addr;
    bit          m_infl;
    bit          m_first;

    task automatic model_reset(input logic [31:0] pc);
        m_q.delete();
        m_fetch_pc = pc;
        m_head_pc  = pc;
        m_infl     = 1'b0;
        m_first    = 1'b1;
    endtask

    task automatic model_step();
        logic [31:0] a;
        logic [31:0] exp_instr;
        bit          flush;
        bit          hit;
        bit          exp_rd;
        a         = cpu_addr & 32'hFFFF_FFFC;
        flush     = cpu_req && (a != m_head_pc);
        hit       = cpu_req && !flush && (m_q.size() > 0);
        exp_rd    = !flush && !m_first && ((m_q.size() + int'(m_infl)) < DEPTH);
        exp_instr = 32'h0;
        if (hit) exp_instr = mem_word(m_q[0]);
        check("model_valid", 32'(cpu_valid), 32'(hit));
        check("model_instr", cpu_instr, exp_instr);
        check("model_mem_rd", 32'(mem_rd), 32'(exp_rd));
        if (exp_rd) check("model_mem_addr", mem_addr, m_fetch_pc);
        if (hit) begin
            void'(m_q.pop_front());
            m_head_pc = m_head_pc + 32'd4;
        end
        if (flush) begin
            m_q.delete();
            m_infl     = 1'b0;
            m_fetch_pc = a;
            m_head_pc  = a;
        end else begin
            if (m_infl) m_q.push_back(m_infl_addr);
            m_infl      = exp_rd;
            m_infl_addr = m_fetch_pc;
            if (exp_rd) m_fetch_pc = m_fetch_pc + 32'd4;
        end
        m_first = 1'b0;
    endtask

    // One clock cycle on the main DUT: sample at negedge, advance the model.
    task automatic tick_obs(output bit v, output logic [31:0] ins, output bit rd);
        @(negedge clk);
        v   = cpu_valid;
        ins = cpu_instr;
        rd  = mem_rd;
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Hold a request and report the cycle index at which it is served.
    task automatic serve(input string name, input logic [31:0] addr, input int want_idx);
        bit          v;
        bit          rd;
        logic [31:0] ins;
        int          idx;
        idx      = -1;
        cpu_req  = 1'b1;
        cpu_addr = addr;
        for (int i = 0; i < 10; i++) begin
            tick_obs(v, ins, rd);
            if (v) begin
                idx = i;
                check({name, "_instr"}, ins, mem_word(addr));
                break;
            end
        end
        check({name, "_latency"}, 32'(idx), 32'(want_idx));
    endtask

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] instr;
        bit          rd;
    } vec_t;

    vec_t        vecs[13];
    logic [31:0] wrap_exp[3];

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          v;
        bit          rd;
        logic [31:0] ins;
        int          pulses;
        int          nrd;
        int          nv;
        int          first_v;
        int          r;

        // Sequential start from reset, then a branch to 0x100.
        vecs[0]  = '{1'b1, 32'h000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 32'h000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[2]  = '{1'b1, 32'h000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[3]  = '{1'b1, 32'h000, 1'b1, 32'h0000_A5A5, 1'b1};
        vecs[4]  = '{1'b1, 32'h004, 1'b1, 32'h0004_A5A5, 1'b1};
        vecs[5]  = '{1'b1, 32'h008, 1'b1, 32'h0008_A5A5, 1'b1};
        vecs[6]  = '{1'b1, 32'h00C, 1'b1, 32'h000C_A5A5, 1'b1};
        vecs[7]  = '{1'b1, 32'h010, 1'b1, 32'h0010_A5A5, 1'b1};
        vecs[8]  = '{1'b1, 32'h100, 1'b0, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b1, 32'h100, 1'b0, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, 32'h100, 1'b0, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b1, 32'h100, 1'b1, 32'h0100_A5A5, 1'b1};
        vecs[12] = '{1'b1, 32'h104, 1'b1, 32'h0104_A5A5, 1'b1};
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;

        rst      = 1'b1;
        rst_w    = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = 32'h0;
        req_w    = 1'b0;
        addr_w   = 32'h0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(cpu_valid), 32'd0);
        check("rst_instr", cpu_instr, 32'h0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_wrap_mem_addr", mem_addr_w, 32'hFFFF_FFF8);
        check("rst_wrap_mem_rd", 32'(mem_rd_w), 32'd0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset(32'h0);

        // Table-driven vectors.
        for (int i = 0; i < 13; i++) begin
            cpu_req  = vecs[i].req;
            cpu_addr = vecs[i].addr;
            tick_obs(v, ins, rd);
            $display("vec %0d: req=%0b addr=%h valid=%0b instr=%h mem_rd=%0b",
                     i, vecs[i].req, vecs[i].addr, v, ins, rd);
            check($sformatf("vec%0d_valid", i), 32'(v), 32'(vecs[i].valid));
            check($sformatf("vec%0d_instr", i), ins, vecs[i].instr);
            check($sformatf("vec%0d_mem_rd", i), 32'(rd), 32'(vecs[i].rd));
        end

        // Idle CPU: prefetch stops after exactly DEPTH reads.
        cpu_req  = 1'b1;
        cpu_addr = 32'h200;
        tick_obs(v, ins, rd);
        cpu_req = 1'b0;
        pulses  = 0;
        for (int i = 0; i < 10; i++) begin
            tick_obs(v, ins, rd);
            if (rd) pulses++;
        end
        $display("idle: mem_rd pulses=%0d last_mem_rd=%0b", pulses, rd);
        check("idle_pulses", 32'(pulses), 32'(DEPTH));
        check("idle_last_mem_rd", 32'(rd), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cpu_req  = 1'b1;
            cpu_addr = 32'h200 + 32'(4 * i);
            tick_obs(v, ins, rd);
            $display("resume %0d: valid=%0b instr=%h", i, v, ins);
            check("resume_valid", 32'(v), 32'd1);
            check("resume_instr", ins, mem_word(cpu_addr));
        end

        // Branch in the cycle right after a read was issued.
        cpu_req = 1'b0;
        rd      = 1'b0;
        for (int i = 0; i < 10 && !rd; i++) begin
            tick_obs(v, ins, rd);
        end
        check("branch_saw_mem_rd", 32'(rd), 32'd1);
        serve("branch", 32'h300, 3);
        cpu_addr = 32'h304;
        tick_obs(v, ins, rd);
        $display("branch next: valid=%0b instr=%h", v, ins);
        check("branch_next_valid", 32'(v), 32'd1);
        check("branch_next_instr", ins, 32'h0304_A5A5);

        // Reset wrap-around with RESET_PC = 0xFFFFFFF8.
        @(posedge clk);
        #1;
        rst_w   = 1'b0;
        req_w   = 1'b1;
        addr_w  = wrap_exp[0];
        nrd     = 0;
        nv      = 0;
        first_v = -1;
        for (int i = 0; i < 20 && nv < 3; i++) begin
            @(negedge clk);
            if (mem_rd_w && nrd < 3) begin
                check("wrap_mem_addr", mem_addr_w, wrap_exp[nrd]);
                nrd++;
            end
            if (valid_w) begin
                if (first_v < 0) first_v = i;
                check("wrap_instr", instr_w, mem_word(wrap_exp[nv]));
                $display("wrap: cycle=%0d instr=%h", i, instr_w);
                nv++;
            end
            @(posedge clk);
            #1;
            if (nv < 3) addr_w = wrap_exp[nv];
        end
        req_w = 1'b0;
        check("wrap_served", 32'(nv), 32'd3);
        check("wrap_first_latency", 32'(first_v), 32'd3);

        // Reset mid-stream with buffered words and a read in flight.
        cpu_req  = 1'b1;
        cpu_addr = 32'h400;
        tick_obs(v, ins, rd);
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) tick_obs(v, ins, rd);
        cpu_req  = 1'b1;
        cpu_addr = 32'h400;
        #1;
        check("prereset_valid", 32'(cpu_valid), 32'd1);
        check("prereset_instr", cpu_instr, 32'h0400_A5A5);
        #1;
        rst = 1'b1;
        #1;
        $display("async reset: valid=%0b instr=%h mem_rd=%0b mem_addr=%h",
                 cpu_valid, cpu_instr, mem_rd, mem_addr);
        check("areset_valid", 32'(cpu_valid), 32'd0);
        check("areset_instr", cpu_instr, 32'h0);
        check("areset_mem_rd", 32'(mem_rd), 32'd0);
        check("areset_mem_addr", mem_addr, 32'h0);
        cpu_addr = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset(32'h0);
        serve("restart", 32'h0, 3);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 15));
            if (r < 3) begin
                cpu_req  = 1'b0;
                cpu_addr = $urandom;
            end else if (r == 3) begin
                cpu_req  = 1'b1;
                cpu_addr = $urandom & 32'h0000_0FFF;
            end else if (r == 4) begin
                cpu_req  = 1'b1;
                cpu_addr = m_head_pc + 32'd4;
            end else begin
                cpu_req  = 1'b1;
                cpu_addr = m_head_pc | 32'($urandom_range(0, 3));
            end
            tick_obs(v, ins, rd);
            if (v) $display("rand %0d: addr=%h instr=%h", i, cpu_addr, ins);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
